// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : HI/LO register owner for the EX stage. Iterative 32-step
//               multiply (signed/unsigned) and restoring unsigned divide,
//               plus MTHI/MTLO writes and MFHI/MFLO combinational reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit #(
    parameter int              DATA_W   = 32,
    parameter int              CTRL_W   = 5,
    parameter logic [CTRL_W-1:0] OP_MULT  = 5'h10,
    parameter logic [CTRL_W-1:0] OP_MULTU = 5'h11,
    parameter logic [CTRL_W-1:0] OP_DIVU  = 5'h12,
    parameter logic [CTRL_W-1:0] OP_MTHI  = 5'h13,
    parameter logic [CTRL_W-1:0] OP_MTLO  = 5'h14,
    parameter logic [CTRL_W-1:0] OP_MFHI  = 5'h15,
    parameter logic [CTRL_W-1:0] OP_MFLO  = 5'h16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hilo_rdata
);

    localparam logic [5:0] c_LAST_STEP = 6'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t              r_state;
    logic [5:0]          r_count;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_neg;
    logic [DATA_W-1:0]   r_mcand;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quot;
    logic [DATA_W-1:0]   r_divisor;

    logic                w_is_mult;
    logic                w_is_mul_any;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_prod_next;
    logic [2*DATA_W-1:0] w_prod_final;
    logic [DATA_W:0]     w_div_shift;
    logic                w_div_ok;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quot_next;

    assign w_is_mult    = (alu_control == OP_MULT);
    assign w_is_mul_any = w_is_mult || (alu_control == OP_MULTU);

    // Negating 0x80000000 wraps to itself, which is its correct unsigned magnitude.
    assign w_mag_a = (w_is_mult && src_a[DATA_W-1]) ? (~src_a + 1'b1) : src_a;
    assign w_mag_b = (w_is_mult && src_b[DATA_W-1]) ? (~src_b + 1'b1) : src_b;

    // Shift-add: upper half accumulates, multiplier drains out of the lower half.
    assign w_mul_sum    = {1'b0, r_prod[2*DATA_W-1:DATA_W]}
                        + (r_prod[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
    assign w_prod_next  = {w_mul_sum, r_prod[DATA_W-1:1]};
    assign w_prod_final = r_neg ? (~w_prod_next + 1'b1) : w_prod_next;

    // Restoring divide step; a kept remainder is always below the divisor.
    assign w_div_shift = {r_rem, r_quot[DATA_W-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_divisor});
    assign w_rem_next  = w_div_ok ? (w_div_shift[DATA_W-1:0] - r_divisor)
                                  : w_div_shift[DATA_W-1:0];
    assign w_quot_next = {r_quot[DATA_W-2:0], w_div_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= 6'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_count <= 6'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_is_mul_any) begin
                                r_mcand <= w_mag_a;
                                r_prod  <= {{DATA_W{1'b0}}, w_mag_b};
                                r_neg   <= w_is_mult && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                                r_count <= 6'd0;
                                r_busy  <= 1'b1;
                                r_state <= S_MUL;
                            end else if (alu_control == OP_DIVU) begin
                                if (src_b == '0) begin
                                    r_hi   <= src_a;
                                    r_lo   <= '1;
                                    r_done <= 1'b1;
                                end else begin
                                    r_rem     <= '0;
                                    r_quot    <= src_a;
                                    r_divisor <= src_b;
                                    r_count   <= 6'd0;
                                    r_busy    <= 1'b1;
                                    r_state   <= S_DIV;
                                end
                            end else if (alu_control == OP_MTHI) begin
                                r_hi   <= src_a;
                                r_done <= 1'b1;
                            end else if (alu_control == OP_MTLO) begin
                                r_lo   <= src_a;
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_MUL: begin
                        r_prod <= w_prod_next;
                        if (r_count == c_LAST_STEP) begin
                            {r_hi, r_lo} <= w_prod_final;
                            r_count      <= 6'd0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_count <= r_count + 6'd1;
                        end
                    end
                    S_DIV: begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        if (r_count == c_LAST_STEP) begin
                            r_hi    <= w_rem_next;
                            r_lo    <= w_quot_next;
                            r_count <= 6'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= r_count + 6'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= 6'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        hilo_rdata = '0;
        if (alu_control == OP_MFHI) begin
            hilo_rdata = r_hi;
        end else if (alu_control == OP_MFLO) begin
            hilo_rdata = r_lo;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// Module      : tb_hilo_muldiv_unit
// Description : Scoreboard bench for hilo_muldiv_unit with a plain-arithmetic
//               HI/LO reference model and randomized operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;

    localparam logic [4:0] c_MULT  = 5'h10;
    localparam logic [4:0] c_MULTU = 5'h11;
    localparam logic [4:0] c_DIVU  = 5'h12;
    localparam logic [4:0] c_MTHI  = 5'h13;
    localparam logic [4:0] c_MTLO  = 5'h14;
    localparam logic [4:0] c_MFHI  = 5'h15;
    localparam logic [4:0] c_MFLO  = 5'h16;
    localparam logic [4:0] c_BOGUS = 5'h1F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  alu_control = 5'h0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_unit #(
        .DATA_W   (32),
        .CTRL_W   (5),
        .OP_MULT  (c_MULT),
        .OP_MULTU (c_MULTU),
        .OP_DIVU  (c_DIVU),
        .OP_MTHI  (c_MTHI),
        .OP_MTLO  (c_MTLO),
        .OP_MFHI  (c_MFHI),
        .OP_MFLO  (c_MFLO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .hilo_rdata  (hilo_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                check("hilo_result", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int busy_exp);
        logic [63:0] p;
        busy_exp = 0;
        case (op)
            c_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
                exp_q.push_back(p);
                busy_exp = 32;
            end
            c_MULT: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                {m_hi, m_lo} = p;
                exp_q.push_back(p);
                busy_exp = 32;
            end
            c_DIVU: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                    busy_exp = 32;
                end
                exp_q.push_back({m_hi, m_lo});
            end
            c_MTHI: begin
                m_hi = a;
                exp_q.push_back({m_hi, m_lo});
            end
            c_MTLO: begin
                m_lo = a;
                exp_q.push_back({m_hi, m_lo});
            end
            default: ;
        endcase
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_control = op;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int exp_busy;
        int got_busy;
        model_op(op, a, b, exp_busy);
        drive_op(op, a, b);
        wait_idle(got_busy);
        check("busy_cycles", 64'(got_busy), 64'(exp_busy));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int          cyc;
        logic [4:0]  ops[5] = '{c_MULT, c_MULTU, c_DIVU, c_MTHI, c_MTLO};
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        issue(c_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(c_MULT, 32'h8000_0000, 32'h8000_0000);
        check("mult_minint", {hi, lo}, 64'h4000_0000_0000_0000);
        issue(c_DIVU, 32'd100, 32'd7);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        issue(c_DIVU, 32'd5, 32'd0);
        check("divu_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

        issue(c_MTHI, 32'h1234_5678, 32'd0);
        alu_control = c_MFLO;
        #1 check("mflo_read", {32'd0, hilo_rdata}, {32'd0, m_lo});
        alu_control = c_MFHI;
        #1 check("mfhi_read", {32'd0, hilo_rdata}, 64'h1234_5678);
        @(negedge clk);
        issue(c_MTLO, 32'hCAFE_F00D, 32'd0);
        check("mtlo_keeps_hi", {hi, lo}, 64'h1234_5678_CAFE_F00D);

        issue(c_MFHI, 32'hDEAD_BEEF, 32'd0);
        issue(c_BOGUS, 32'hDEAD_BEEF, 32'd3);
        repeat (3) @(negedge clk);
        check("noop_keeps_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush mid-multiply: no commit, no done, reads stay on the pre-op value.
        drive_op(c_MULTU, 32'h0001_0003, 32'h0002_0005);
        repeat (9) @(negedge clk);
        check("busy_before_flush", {63'd0, busy}, 64'd1);
        alu_control = c_MFHI;
        #1 check("mfhi_during_busy", {32'd0, hilo_rdata}, {32'd0, m_hi});
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_drop", {63'd0, busy}, 64'd0);
        check("flush_keeps_hilo", {hi, lo}, {m_hi, m_lo});
        repeat (40) @(negedge clk);

        alu_control = c_MULTU;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("start_flush_rejected", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);

        // A start pulse while busy must be ignored.
        issue_mid_mtlo: begin
            int exp_busy;
            model_op(c_DIVU, 32'd123_456_789, 32'd1000, exp_busy);
            drive_op(c_DIVU, 32'd123_456_789, 32'd1000);
            repeat (4) @(negedge clk);
            alu_control = c_MTLO;
            src_a = 32'hBAD0_BAD0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_idle(cyc);
            check("busy_with_ignored_start", 64'(cyc), 64'(exp_busy - 5));
        end

        for (int i = 0; i < 24; i++) begin
            a = pick_operand();
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : pick_operand();
            issue(ops[$urandom_range(0, 4)], a, b);
        end
        repeat (2) @(negedge clk);

        // Reset mid-divide clears everything immediately.
        drive_op(c_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_no_commit", {hi, lo}, 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
